tlb_miss_reporter: RTL and testbench

TLB_MISS_REPORTER -- requirements
Module: tlb_miss_reporter

---
 rtl/tlb_miss_reporter.sv | 160 ++++++++++++++++
 tb/tb_tlb_miss_reporter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tlb_miss_reporter.sv
// TLB miss reporter: posts the faulting VA as two 32-bit TCDM writes to a miss-queue
// window, waits for the handled response, then reports status and miss latency.
`timescale 1ns/1ps
module tlb_miss_reporter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LAT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 miss_valid_i,
  input  logic [63:0]          miss_va_i,
  output logic                 miss_ready_o,
  output logic                 req_o,
  output logic [31:0]          add_o,
  output logic                 wen_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  input  logic                 gnt_i,
  input  logic                 r_valid_i,
  input  logic [31:0]          r_rdata_i,
  output logic                 done_o,
  output logic                 done_err_o,
  output logic [LAT_WIDTH-1:0] latency_o,
  output logic                 spurious_o
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_REQ_LOW      = 3'd1,
    S_WAIT_LOW     = 3'd2,
    S_REQ_HIGH     = 3'd3,
    S_WAIT_HANDLED = 3'd4,
    S_DONE         = 3'd5
  } state_e;

  localparam logic [LAT_WIDTH-1:0] LAT_ONE = {{(LAT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LAT_WIDTH-1:0] LAT_MAX = {LAT_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [63:0]            va_q, va_d;
  logic [LAT_WIDTH-1:0]   lat_q, lat_d;
  logic                   err_q, err_d;
  logic                   spurious_q, spurious_d;
  logic [LAT_WIDTH-1:0]   lat_inc_s;
  logic                   spur_win_s;

  // State and capture registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      va_q       <= 64'h0;
      lat_q      <= '0;
      err_q      <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      va_q       <= va_d;
      lat_q      <= lat_d;
      err_q      <= err_d;
      spurious_q <= spurious_d;
    end
  end

  // Next-state, saturating latency, spurious-response tracking and output decode
  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    lat_d        = lat_q;
    err_d        = err_q;
    miss_ready_o = 1'b0;
    req_o        = 1'b0;
    add_o        = 32'h0;
    wen_o        = 1'b1;
    wdata_o      = 32'h0;
    be_o         = 4'h0;
    done_o       = 1'b0;
    done_err_o   = 1'b0;
    latency_o    = '0;

    lat_inc_s  = (lat_q == LAT_MAX) ? lat_q : (lat_q + LAT_ONE);
    // Responses are only meaningful in the wait states; anywhere else they are strays
    spur_win_s = (state_q == S_IDLE) || (state_q == S_REQ_LOW) ||
                 (state_q == S_REQ_HIGH) || (state_q == S_DONE);
    spurious_d = spurious_q | (r_valid_i & spur_win_s);

    case (state_q)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          va_d    = miss_va_i;
          lat_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ_LOW;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ_LOW: begin
        req_o   = 1'b1;
        add_o   = BASE_ADDR + 32'h0000_0000;
        wen_o   = 1'b0;
        wdata_o = va_q[31:0];
        be_o    = 4'hF;
        lat_d   = lat_inc_s;
        if (gnt_i) begin
          state_d = S_WAIT_LOW;
        end else begin
          state_d = S_REQ_LOW;
        end
      end
      S_WAIT_LOW: begin
        lat_d = lat_inc_s;
        if (r_valid_i) begin
          if (r_rdata_i == 32'h0) begin
            state_d = S_REQ_HIGH;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_WAIT_LOW;
        end
      end
      S_REQ_HIGH: begin
        req_o   = 1'b1;
        add_o   = BASE_ADDR + 32'h0000_0004;
        wen_o   = 1'b0;
        wdata_o = va_q[63:32];
        be_o    = 4'hF;
        lat_d   = lat_inc_s;
        if (gnt_i) begin
          state_d = S_WAIT_HANDLED;
        end else begin
          state_d = S_REQ_HIGH;
        end
      end
      S_WAIT_HANDLED: begin
        lat_d = lat_inc_s;
        if (r_valid_i) begin
          err_d   = (r_rdata_i != 32'h0);
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_HANDLED;
        end
      end
      S_DONE: begin
        done_o     = 1'b1;
        done_err_o = err_q;
        latency_o  = lat_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_tlb_miss_reporter.sv
// Directed self-checking bench for tlb_miss_reporter: a 32-bit and a 4-bit latency
// instance share all stimulus; writes are captured independently at the TCDM port.
`timescale 1ns/1ps
module tb_tlb_miss_reporter;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        miss_valid;
  logic [63:0] miss_va;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;

  logic        ready_a, req_a, wen_a, done_a, err_a, spur_a;
  logic [31:0] add_a, wdata_a, lat_a;
  logic [3:0]  be_a;

  logic        ready_b, req_b, wen_b, done_b, err_b, spur_b;
  logic [31:0] add_b, wdata_b;
  logic [3:0]  be_b, lat_b;

  int total = 0;
  int bad   = 0;
  logic [63:0] wr_q[$];

  tlb_miss_reporter #(.BASE_ADDR(BASE), .LAT_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .miss_valid_i(miss_valid), .miss_va_i(miss_va),
    .miss_ready_o(ready_a), .req_o(req_a), .add_o(add_a), .wen_o(wen_a),
    .wdata_o(wdata_a), .be_o(be_a), .gnt_i(gnt), .r_valid_i(r_valid),
    .r_rdata_i(r_rdata), .done_o(done_a), .done_err_o(err_a),
    .latency_o(lat_a), .spurious_o(spur_a)
  );

  tlb_miss_reporter #(.BASE_ADDR(BASE), .LAT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .miss_valid_i(miss_valid), .miss_va_i(miss_va),
    .miss_ready_o(ready_b), .req_o(req_b), .add_o(add_b), .wen_o(wen_b),
    .wdata_o(wdata_b), .be_o(be_b), .gnt_i(gnt), .r_valid_i(r_valid),
    .r_rdata_i(r_rdata), .done_o(done_b), .done_err_o(err_b),
    .latency_o(lat_b), .spurious_o(spur_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every granted write on the wide instance
  always @(posedge clk) begin
    if (!rst && req_a && gnt) begin
      wr_q.push_back({add_a, wdata_a});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // One complete miss; called at a negedge with the DUT in Idle
  task automatic run_miss(input logic [63:0] va, input int stall, input int wl,
                          input logic [31:0] rd_lo, input int wh, input logic [31:0] rd_hi,
                          input logic exp_err, input logic [31:0] exp_lat,
                          input logic [3:0] exp_lat_b);
    chk("idle_ready", {63'd0, ready_a}, 64'd1);
    miss_valid = 1'b1;
    miss_va    = va;
    cyc();
    miss_valid = 1'b0;
    miss_va    = 64'h0;
    chk("reqlow_not_ready", {63'd0, ready_a}, 64'd0);
    for (int s = 0; s <= stall; s++) begin
      chk("reqlow_req",   {63'd0, req_a}, 64'd1);
      chk("reqlow_add",   {32'd0, add_a}, {32'd0, BASE});
      chk("reqlow_wdata", {32'd0, wdata_a}, {32'd0, va[31:0]});
      chk("reqlow_wen_be", {59'd0, wen_a, be_a}, {59'd0, 1'b0, 4'hF});
      gnt = (s == stall);
      cyc();
    end
    gnt = 1'b0;
    chk("waitlow_req", {63'd0, req_a}, 64'd0);
    chk("waitlow_idle_bus", {27'd0, wen_a, be_a, add_a}, {27'd0, 1'b1, 4'h0, 32'h0});
    repeat (wl - 1) cyc();
    r_valid = 1'b1;
    r_rdata = rd_lo;
    cyc();
    r_valid = 1'b0;
    r_rdata = 32'h0;
    if (rd_lo == 32'h0) begin
      chk("reqhigh_add",   {32'd0, add_a}, {32'd0, BASE + 32'h4});
      chk("reqhigh_wdata", {32'd0, wdata_a}, {32'd0, va[63:32]});
      gnt = 1'b1;
      cyc();
      gnt = 1'b0;
      chk("waithandled_req", {63'd0, req_a}, 64'd0);
      repeat (wh - 1) cyc();
      r_valid = 1'b1;
      r_rdata = rd_hi;
      cyc();
      r_valid = 1'b0;
      r_rdata = 32'h0;
    end
    chk("done_pulse",   {62'd0, done_a, done_b}, 64'd3);
    chk("done_err",     {62'd0, err_a, err_b}, {62'd0, exp_err, exp_err});
    chk("done_latency", {32'd0, lat_a}, {32'd0, exp_lat});
    chk("done_latency_sat4", {60'd0, lat_b}, {60'd0, exp_lat_b});
    chk("write_count", 64'(wr_q.size()), (rd_lo == 32'h0) ? 64'd2 : 64'd1);
    if (wr_q.size() >= 1) chk("write_low", wr_q[0], {BASE, va[31:0]});
    if (wr_q.size() >= 2) chk("write_high", wr_q[1], {BASE + 32'h4, va[63:32]});
    wr_q.delete();
    cyc();
    chk("after_done_quiet", {31'd0, done_a, err_a, lat_a}, 64'd0);
    chk("no_spurious", {62'd0, spur_a, spur_b}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_va    = 64'h0;
    gnt        = 1'b0;
    r_valid    = 1'b0;
    r_rdata    = 32'h0;
    cyc();
    cyc();
    chk("reset_state", {58'd0, ready_a, req_a, done_a, spur_a, wen_a, ready_b},
        {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    chk("reset_bus", {28'd0, be_a, add_a}, 64'd0);
    rst = 1'b0;
    cyc();

    // Nominal: 1 + 3 + 1 + 20 = 25 cycles
    run_miss(64'h0000_0012_3456_7000, 0, 3, 32'h0, 20, 32'h0, 1'b0, 32'd25, 4'hF);
    // Low grant stalled 5 cycles: 30 cycles
    run_miss(64'h0000_0012_3456_7000, 5, 3, 32'h0, 20, 32'h0, 1'b0, 32'd30, 4'hF);
    // Low-write error: done three cycles after acceptance
    run_miss(64'hCAFE_0000_0000_1234, 0, 2, 32'h1, 1, 32'h0, 1'b1, 32'd3, 4'd3);
    // Handled error, immediately followed by the next miss (saturation case)
    run_miss(64'h8000_0000_ABCD_EF00, 0, 1, 32'h0, 1, 32'hDEAD, 1'b1, 32'd4, 4'd4);
    run_miss(64'hFFFF_FFFF_0000_0001, 0, 1, 32'h0, 30, 32'h0, 1'b0, 32'd33, 4'hF);

    // Response coinciding with the low grant is a stray, not the low response
    miss_valid = 1'b1;
    miss_va    = 64'h0000_0001_0000_0002;
    cyc();
    miss_valid = 1'b0;
    gnt        = 1'b1;
    r_valid    = 1'b1;
    cyc();
    gnt     = 1'b0;
    r_valid = 1'b0;
    chk("grant_resp_spurious", {62'd0, spur_a, spur_b}, 64'd3);
    cyc();
    chk("grant_resp_still_waiting", {61'd0, req_a, done_a, ready_a}, 64'd0);
    r_valid = 1'b1;
    cyc();
    r_valid = 1'b0;
    chk("reqhigh_after_stray", {32'd0, add_a}, {32'd0, BASE + 32'h4});
    gnt = 1'b1;
    cyc();
    gnt = 1'b0;
    cyc();
    // Reset in WaitHandled abandons the miss
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("reset_mid_idle", {60'd0, ready_a, done_a, spur_a, req_a}, {60'd0, 4'b1000});
    cyc();
    r_valid = 1'b1;
    cyc();
    r_valid = 1'b0;
    chk("stale_resp_spurious", {62'd0, spur_a, spur_b}, 64'd3);
    chk("stale_resp_no_done", {62'd0, done_a, ready_a}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stale_no_done_later", {62'd0, done_a, spur_a}, 64'd1);
    end
    wr_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
